// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// reset/NOP defaults and PC arithmetic helpers.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] IFU_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_INCR       = 32'd4;

    // Instruction addresses are word aligned; low two bits are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: instruction, next PC and valid bit.
// Priority is reset/flush, then load, otherwise hold.
module if_id_reg
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_npc,
    output logic [31:0] o_instr,
    output logic [31:0] o_npc,
    output logic        o_valid
);

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            o_instr <= NOP_INSTR;
            o_npc   <= 32'h0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_instr <= i_instr;
            o_npc   <= i_npc;
            o_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM and a
// one-word holding buffer for responses that arrive while decode is stalled.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instruction_out,
    output logic [31:0] if_id_npc_out,
    output logic        if_id_valid
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_hold_instr;

    logic         w_handshake;
    logic         w_load;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_load_instr;

    // While reset is high the port already presents the reset fetch.
    assign imem_req     = reset | (r_state == REQ);
    assign imem_addr    = reset ? RESET_PC : r_pc;
    assign w_handshake  = imem_req & imem_ready;
    assign w_pc_next    = r_pc + PC_INCR;
    assign w_load       = !redirect && !stall &&
                          (((r_state == WAIT) && imem_rvalid) || (r_state == HOLD));
    assign w_load_instr = (r_state == HOLD) ? r_hold_instr : imem_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= REQ;
            r_pc         <= RESET_PC;
            r_hold_instr <= 32'h0;
        end else if (redirect) begin
            // A response still owed by memory must be drained before refetching.
            r_pc <= align_pc(redirect_pc);
            case (r_state)
                REQ:     r_state <= w_handshake ? DROP : REQ;
                WAIT:    r_state <= imem_rvalid ? REQ : DROP;
                HOLD:    r_state <= REQ;
                DROP:    r_state <= imem_rvalid ? REQ : DROP;
                default: r_state <= REQ;
            endcase
        end else begin
            case (r_state)
                REQ: begin
                    if (w_handshake) r_state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            r_hold_instr <= imem_rdata;
                            r_state      <= HOLD;
                        end else begin
                            r_pc    <= w_pc_next;
                            r_state <= REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_pc    <= w_pc_next;
                        r_state <= REQ;
                    end
                end
                DROP: begin
                    if (imem_rvalid) r_state <= REQ;
                end
                default: r_state <= REQ;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_load),
        .i_flush (redirect),
        .i_instr (w_load_instr),
        .i_npc   (w_pc_next),
        .o_instr (if_id_instruction_out),
        .o_npc   (if_id_npc_out),
        .o_valid (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: per-cycle vector table, an IF/ID
// scoreboard, and a second instance with RESET_PC at the top of memory.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] Z   = 32'h0;
    localparam logic        H   = 1'b1;
    localparam logic        L   = 1'b0;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        st;
        logic        rdr;
        logic [31:0] rpc;
        logic        push;
        logic [31:0] sb_npc;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        logic        e_valid;
        logic [31:0] e_addr2;
        logic [31:0] e_npc2;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } sb_t;

    logic        clock;
    logic        reset;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req,   imem_req2;
    logic [31:0] imem_addr,  imem_addr2;
    logic [31:0] ifid_instr, ifid_instr2;
    logic [31:0] ifid_npc,   ifid_npc2;
    logic        ifid_valid, ifid_valid2;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs [24];
    sb_t  sbq  [$];
    logic [64:0] prev_snap;

    instruction_fetch_unit dut (
        .clock                 (clock),
        .reset                 (reset),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_ready            (imem_ready),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .stall                 (stall),
        .redirect              (redirect),
        .redirect_pc           (redirect_pc),
        .if_id_instruction_out (ifid_instr),
        .if_id_npc_out         (ifid_npc),
        .if_id_valid           (ifid_valid)
    );

    // Same stimulus; its FSM runs in lockstep, only the PC differs.
    instruction_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clock                 (clock),
        .reset                 (reset),
        .imem_req              (imem_req2),
        .imem_addr             (imem_addr2),
        .imem_ready            (imem_ready),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .stall                 (stall),
        .redirect              (redirect),
        .redirect_pc           (redirect_pc),
        .if_id_instruction_out (ifid_instr2),
        .if_id_npc_out         (ifid_npc2),
        .if_id_valid           (ifid_valid2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one clock, then check any fresh IF/ID load against the scoreboard.
    task automatic step();
        logic [64:0] snap;
        sb_t         e;
        @(posedge clock);
        #1;
        snap = {ifid_valid, ifid_instr, ifid_npc};
        if (snap !== prev_snap && ifid_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_load", ifid_instr, 32'hXXXX_XXXX);
            end else begin
                e = sbq.pop_front();
                chk("sb_instr", ifid_instr, e.instr);
                chk("sb_npc", ifid_npc, e.npc);
            end
        end
        prev_snap = snap;
    endtask

    initial begin
        vecs[0]  = '{H,L,Z,L,L,Z,L,Z, L,32'h0,NOP,Z,L, 32'hFFFF_FFFC,Z};
        vecs[1]  = '{L,H,32'hA000_0000,L,L,Z,H,32'h4, H,32'h4,32'hA000_0000,32'h4,H, Z,Z};
        vecs[2]  = '{H,L,Z,L,L,Z,L,Z, L,32'h4,32'hA000_0000,32'h4,H, Z,Z};
        vecs[3]  = '{L,H,32'hA000_0001,L,L,Z,H,32'h8, H,32'h8,32'hA000_0001,32'h8,H, 32'h4,32'h4};
        vecs[4]  = '{H,L,Z,L,L,Z,L,Z, L,32'h8,32'hA000_0001,32'h8,H, 32'h4,32'h4};
        vecs[5]  = '{L,H,32'hA000_0002,L,L,Z,H,32'hC, H,32'hC,32'hA000_0002,32'hC,H, 32'h8,32'h8};
        vecs[6]  = '{H,L,Z,L,L,Z,L,Z, L,32'hC,32'hA000_0002,32'hC,H, 32'h8,32'h8};
        vecs[7]  = '{L,H,32'hDEAD_BEEF,H,L,Z,H,32'h10, L,32'hC,32'hA000_0002,32'hC,H, 32'h8,32'h8};
        vecs[8]  = '{H,L,Z,H,L,Z,L,Z, L,32'hC,32'hA000_0002,32'hC,H, 32'h8,32'h8};
        vecs[9]  = '{L,L,Z,L,L,Z,L,Z, H,32'h10,32'hDEAD_BEEF,32'h10,H, 32'hC,32'hC};
        vecs[10] = '{H,L,Z,H,L,Z,L,Z, L,32'h10,32'hDEAD_BEEF,32'h10,H, 32'hC,32'hC};
        vecs[11] = '{L,L,Z,L,H,32'h103,L,Z, L,32'h100,NOP,Z,L, 32'h100,Z};
        vecs[12] = '{L,H,32'hBAD0_0000,L,L,Z,L,Z, H,32'h100,NOP,Z,L, 32'h100,Z};
        vecs[13] = '{H,L,Z,L,L,Z,L,Z, L,32'h100,NOP,Z,L, 32'h100,Z};
        vecs[14] = '{L,H,32'hB000_0000,L,L,Z,H,32'h104, H,32'h104,32'hB000_0000,32'h104,H, 32'h104,32'h104};
        vecs[15] = '{H,L,Z,L,L,Z,L,Z, L,32'h104,32'hB000_0000,32'h104,H, 32'h104,32'h104};
        vecs[16] = '{L,H,32'hC000_0000,H,L,Z,L,Z, L,32'h104,32'hB000_0000,32'h104,H, 32'h104,32'h104};
        vecs[17] = '{L,L,Z,H,H,32'h200,L,Z, H,32'h200,NOP,Z,L, 32'h200,Z};
        vecs[18] = '{H,L,Z,L,L,Z,L,Z, L,32'h200,NOP,Z,L, 32'h200,Z};
        vecs[19] = '{L,H,32'hD000_0000,L,L,Z,H,32'h204, H,32'h204,32'hD000_0000,32'h204,H, 32'h204,32'h204};
        vecs[20] = '{L,L,Z,L,H,32'h300,L,Z, H,32'h300,NOP,Z,L, 32'h300,Z};
        vecs[21] = '{H,L,Z,L,H,32'h400,L,Z, L,32'h400,NOP,Z,L, 32'h400,Z};
        vecs[22] = '{L,L,Z,L,L,Z,L,Z, L,32'h400,NOP,Z,L, 32'h400,Z};
        vecs[23] = '{L,H,32'hEEEE_0000,L,L,Z,L,Z, H,32'h400,NOP,Z,L, 32'h400,Z};

        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        prev_snap   = '0;

        step();
        chk("rst_req", {31'h0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_npc", ifid_npc, 32'h0);
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
        step();
        reset = 1'b0;
        step();
        chk("idle_req", {31'h0, imem_req}, 32'h1);
        chk("idle_addr", imem_addr, 32'h0);

        for (int i = 0; i < 24; i++) begin
            imem_ready  = vecs[i].rdy;
            imem_rvalid = vecs[i].rv;
            imem_rdata  = vecs[i].rdata;
            stall       = vecs[i].st;
            redirect    = vecs[i].rdr;
            redirect_pc = vecs[i].rpc;
            if (vecs[i].push) sbq.push_back('{vecs[i].rdata, vecs[i].sb_npc});
            step();
            chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_instr", i), ifid_instr, vecs[i].e_instr);
            chk($sformatf("v%0d_npc", i), ifid_npc, vecs[i].e_npc);
            chk($sformatf("v%0d_valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d_addr_wrap", i), imem_addr2, vecs[i].e_addr2);
            chk($sformatf("v%0d_npc_wrap", i), ifid_npc2, vecs[i].e_npc2);
        end

        // Reset in the middle of a transaction, then a stray response.
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        step();
        chk("mid_wait_req", {31'h0, imem_req}, 32'h0);
        reset      = 1'b1;
        imem_ready = 1'b0;
        step();
        chk("mid_rst_req", {31'h0, imem_req}, 32'h1);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_instr", ifid_instr, NOP);
        chk("mid_rst_npc", ifid_npc, 32'h0);
        chk("mid_rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("mid_rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hEEEE_0001;
        step();
        chk("stray_req", {31'h0, imem_req}, 32'h1);
        chk("stray_addr", imem_addr, 32'h0);
        chk("stray_valid", {31'h0, ifid_valid}, 32'h0);
        chk("stray_instr", ifid_instr, NOP);
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        step();
        chk("refetch_req", {31'h0, imem_req}, 32'h0);
        chk("refetch_addr", imem_addr, 32'h0);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hF000_0000;
        sbq.push_back('{32'hF000_0000, 32'h4});
        step();
        chk("refetch_instr", ifid_instr, 32'hF000_0000);
        chk("refetch_npc", ifid_npc, 32'h4);
        chk("refetch_valid", {31'h0, ifid_valid}, 32'h1);
        imem_rvalid = 1'b0;
        step();
        chk("sb_drained", sbq.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the five-stage pipeline. It owns the program counter, fetches instruction words over a request/response instruction-memory port, and drives the IF/ID pipeline register consumed by the decode stage (`if_id_instruction_out`, `if_id_npc_out`). It honours stalls from the hazard unit and branch redirects from EX/MEM. At most one memory request is outstanding at any time.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): instruction injected into IF/ID on reset and on flush.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  fetch address; always equals the current PC.
- `imem_ready`  in  1  memory accepts the request; handshake is `imem_req & imem_ready`.
- `imem_rvalid`  in  1  response valid. Earliest assertion is one cycle after the handshake.
- `imem_rdata`  in  32  instruction word, qualified by `imem_rvalid`.
- `stall`  in  1  hold the IF/ID register and the PC.
- `redirect`  in  1  taken branch or jump; flush and load a new PC.
- `redirect_pc`  in  32  new PC; bits [1:0] are forced to 0.
- `if_id_instruction_out`  out  32  IF/ID instruction.
- `if_id_npc_out`  out  32  IF/ID next PC, equal to fetch PC + 4.
- `if_id_valid`  out  1  IF/ID holds a real instruction.

## Operation
- State machine states: REQ, WAIT, HOLD, DROP. There is also a 32-bit holding buffer `hold_instr`.
- **REQ**
  - `imem_req`=1 and `imem_addr`=pc.
  - On handshake, go to WAIT.
  - `imem_addr` may change while no handshake has occurred.
  - `imem_rvalid` is ignored in this state.
- **WAIT**
  - When `imem_rvalid` arrives with `stall`=0: load IF/ID with {`imem_rdata`, pc+4, valid=1}, set pc←pc+4, go to REQ.
  - When `imem_rvalid` arrives with `stall`=1: set `hold_instr`←`imem_rdata` and go to HOLD. IF/ID and pc are unchanged.
- **HOLD**
  - `imem_req`=0.
  - When `stall` falls: load IF/ID with {`hold_instr`, pc+4, 1}, set pc←pc+4, go to REQ.
- **DROP**
  - Waits for the stale response.
  - On `imem_rvalid`, discard the data and go to REQ.
- **Redirect** has the highest priority and overrides `stall`.
  - pc←`redirect_pc` with bits [1:0] cleared.
  - IF/ID←{`NOP_INSTR`, 32'h0, 0}.
  - Next state, by current state:
    - REQ with handshake this cycle: DROP.
    - REQ without handshake: REQ.
    - WAIT with no `imem_rvalid`: DROP.
    - WAIT with `imem_rvalid`: REQ, data discarded.
    - HOLD: REQ, buffer discarded.
    - DROP with `imem_rvalid`: REQ.
    - DROP with no `imem_rvalid`: DROP.
- **Stall** only holds IF/ID and pc. A request may still be issued from REQ while `stall`=1.
- **Arithmetic**: pc+4 is computed modulo 2^32, so 32'hFFFF_FFFC+4 gives 0.
- **Reset values**: pc=`RESET_PC`, state=REQ, `if_id_instruction_out`=`NOP_INSTR`, `if_id_npc_out`=0, `if_id_valid`=0, `hold_instr`=0.
  - Outputs with `reset` high: `imem_req`=1, `imem_addr`=`RESET_PC`.
  - A reset during WAIT, HOLD or DROP abandons the transaction. The instruction memory shares `reset`, and any stray `imem_rvalid` seen in REQ is ignored.

## Timing
- `imem_req` and `imem_addr` are combinational from state and pc. All other outputs are registered.
- Minimum fetch latency: handshake in cycle t, `imem_rvalid` in cycle t+1, IF/ID visible in cycle t+2.
- Peak throughput is one instruction per 2 cycles, since there is no request pipelining.
- A redirect asserted in cycle t gives `imem_addr`=`redirect_pc` in cycle t+1 when the state is REQ. Otherwise it appears once the stale response has been drained.
- A flush appears on the IF/ID outputs in cycle t+1.
- Deasserting `stall` in cycle t while in HOLD gives the held instruction on IF/ID in cycle t+1.

## Structure
- Shared package contents:
  - state enum {REQ, WAIT, HOLD, DROP};
  - `NOP_INSTR` constant;
  - `RESET_PC` default;
  - PC increment constant 4.
- One sub-module, `if_id_reg`, holds instruction, npc and valid, with load, hold and flush controls.
  - Flush beats load, and load beats hold.
  - The FSM, PC and holding buffer live in `instruction_fetch_unit`.

## Test plan
1. **Reset and fetch**: deassert reset with memory ready=1 and rvalid one cycle after each handshake.
   - Expect addresses 0, 4, 8 on successive handshakes.
   - IF/ID shows each word with npc 4, 8, 12 and valid=1, every 2 cycles.
2. **Stall during WAIT**: assert `stall` when rvalid returns 32'hDEAD_BEEF.
   - IF/ID keeps its previous value and `imem_req`=0.
   - Drop stall; the next edge loads DEAD_BEEF with npc=pc+4.
3. **Redirect before response**: redirect in WAIT with `redirect_pc`=0x103, then rvalid one cycle later.
   - The late data is dropped.
   - The next `imem_addr` is 0x100.
   - IF/ID reads {0x13, 0, 0}.
4. **Redirect and stall together**: assert both in HOLD.
   - Redirect wins: IF/ID is flushed, the buffer is discarded, and the state goes to REQ with the new pc.
5. **PC wrap-around**: set `RESET_PC`=0xFFFF_FFFC.
   - The first IF/ID npc is 0x0000_0000.
   - The second request address is 0.
6. **Reset mid-transaction**: assert reset in WAIT, then inject a stray rvalid after reset.
   - All outputs take their reset values.
   - The stray rvalid is ignored and the next handshake is at `RESET_PC`.
